// File: rtl/hex_cmd_parser.sv
// hex_cmd_parser: parses ASCII "<hexA>*<hexB><CR|LF>" lines into operand pairs
// with a valid/ready handshake and one-cycle error pulses.
module hex_cmd_parser #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    output logic [4*DIGITS-1:0]   op_a,
    output logic [4*DIGITS-1:0]   op_b,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  err,
    output logic [1:0]            err_code
);
    localparam int OP_W = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] MAXC = CW'(DIGITS);

    typedef enum logic [1:0] {GET_A, GET_B, HOLD} state_t;

    state_t          r_state;
    logic [OP_W-1:0] r_acc_a, r_acc_b;
    logic [CW-1:0]   r_cnt_a, r_cnt_b;

    logic          w_dig, w_uc, w_lc, w_hex, w_star, w_term, w_space, w_bad;
    logic [3:0]    w_nib;
    logic          w_sel_b, w_live, w_empty, w_full;
    logic          w_e1, w_e2, w_e3, w_ovr, w_acc, w_to_b, w_load, w_hs, w_clear;
    logic [CW-1:0] w_cnt;

    always_comb begin
        w_dig   = rx_data >= 8'h30 && rx_data <= 8'h39;
        w_uc    = rx_data >= 8'h41 && rx_data <= 8'h46;
        w_lc    = rx_data >= 8'h61 && rx_data <= 8'h66;
        w_hex   = w_dig || w_uc || w_lc;
        w_nib   = w_dig ? rx_data[3:0] : rx_data[3:0] + 4'd9;
        w_star  = rx_data == 8'h2A;
        w_term  = rx_data == 8'h0D || rx_data == 8'h0A;
        w_space = rx_data == 8'h20;
        w_bad   = !(w_hex || w_star || w_term || w_space);
        w_sel_b = r_state == GET_B;
        w_cnt   = w_sel_b ? r_cnt_b : r_cnt_a;
        w_empty = w_cnt == '0;
        w_full  = w_cnt == MAXC;
        w_live  = rx_done && r_state != HOLD && !w_space;
        w_e1    = w_live && w_bad;
        w_e2    = w_live && w_hex && w_full;
        w_e3    = w_live && ((w_star && (w_sel_b || w_empty)) ||
                             (w_term && (w_sel_b ? w_empty : !w_empty)));
        w_ovr   = rx_done && r_state == HOLD;
        w_acc   = w_live && w_hex && !w_full;
        w_to_b  = w_live && w_star && !w_sel_b && !w_empty;
        w_load  = w_live && w_term && w_sel_b && !w_empty;
        w_hs    = r_state == HOLD && cmd_valid && cmd_ready;
        w_clear = w_e1 || w_e2 || w_e3 || w_hs;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= GET_A;
            r_acc_a   <= '0;
            r_acc_b   <= '0;
            r_cnt_a   <= '0;
            r_cnt_b   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            cmd_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            err      <= w_e1 || w_e2 || w_e3 || w_ovr;
            err_code <= w_e1 ? 2'd1 : w_e2 ? 2'd2 : w_e3 ? 2'd3 : 2'd0;
            if (w_clear) begin
                r_state <= GET_A;
                r_acc_a <= '0;
                r_acc_b <= '0;
                r_cnt_a <= '0;
                r_cnt_b <= '0;
                if (w_hs) cmd_valid <= 1'b0;
            end else if (w_acc) begin
                if (w_sel_b) begin
                    r_acc_b <= {r_acc_b[OP_W-5:0], w_nib};
                    r_cnt_b <= r_cnt_b + 1'b1;
                end else begin
                    r_acc_a <= {r_acc_a[OP_W-5:0], w_nib};
                    r_cnt_a <= r_cnt_a + 1'b1;
                end
            end else if (w_to_b) begin
                r_state <= GET_B;
            end else if (w_load) begin
                op_a      <= r_acc_a;
                op_b      <= r_acc_b;
                cmd_valid <= 1'b1;
                r_state   <= HOLD;
            end
        end
    end
endmodule

// File: tb/tb_hex_cmd_parser.sv
// tb_hex_cmd_parser: directed line-by-line checks of the hex command parser.
module tb_hex_cmd_parser;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [15:0] op_a, op_b;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        err;
    logic [1:0]  err_code;
    int          n_chk = 0;
    int          n_err = 0;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    hex_cmd_parser #(.DIGITS(4)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .op_a(op_a), .op_b(op_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) put(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic accept(input string tag);
        cmd_ready = 1'b1;
        idle(1);
        chk({tag, "_valid_drop"}, cmd_valid, 0);
        cmd_ready = 1'b0;
    endtask

    task automatic expect_cmd(input string tag, input logic [15:0] a, input logic [15:0] b);
        chk({tag, "_valid"}, cmd_valid, 1);
        chk({tag, "_op_a"}, op_a, a);
        chk({tag, "_op_b"}, op_b, b);
        chk({tag, "_noerr"}, err, 0);
    endtask

    task automatic expect_err(input string tag, input logic [1:0] code);
        chk({tag, "_err"}, err, 1);
        chk({tag, "_code"}, err_code, code);
    endtask

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; cmd_ready = 1'b0;
        idle(2);
        reset = 1'b0;
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);

        send("12*AB"); put(CR);
        expect_cmd("t1", 16'h0012, 16'h00AB);
        idle(5);
        expect_cmd("t1_hold", 16'h0012, 16'h00AB);
        accept("t1");
        chk("t1_op_a_kept", op_a, 16'h0012);

        cmd_ready = 1'b1;
        send("fFfF * 1"); put(CR);
        expect_cmd("t2", 16'hFFFF, 16'h0001);
        idle(1);
        chk("t2_valid_drop", cmd_valid, 0);
        put(LF);
        chk("t2_lf_noerr", err, 0);
        chk("t2_lf_novalid", cmd_valid, 0);
        cmd_ready = 1'b0;

        send("1234");
        chk("t3_4dig_noerr", err, 0);
        put("5");
        expect_err("t3_ovf", 2'd2);
        put("*");
        expect_err("t3_star", 2'd3);
        put("1"); put(CR);
        expect_err("t3_term", 2'd3);
        idle(1);
        chk("t3_err_drop", err, 0);
        send("7*3"); put(CR);
        expect_cmd("t3", 16'h0007, 16'h0003);
        accept("t3");

        put("*");
        expect_err("t4_lead_star", 2'd3);
        put("5"); put(CR);
        expect_err("t4_a_term", 2'd3);
        send("5*"); put(CR);
        expect_err("t4_empty_b", 2'd3);
        put("G");
        expect_err("t4_bad", 2'd1);
        put(CR);
        chk("t4_blank_term_noerr", err, 0);
        send("1**");
        expect_err("t4_star_in_b", 2'd3);
        put(CR);
        chk("t4_novalid", cmd_valid, 0);

        send("2*3"); put(CR);
        expect_cmd("t5", 16'h0002, 16'h0003);
        put("X");
        expect_err("t5_ovr", 2'd0);
        chk("t5_valid_kept", cmd_valid, 1);
        chk("t5_op_a_kept", op_a, 16'h0002);
        chk("t5_op_b_kept", op_b, 16'h0003);
        idle(1);
        chk("t5_err_drop", err, 0);
        chk("t5_still_valid", cmd_valid, 1);
        accept("t5");
        send("4*4"); put(CR);
        expect_cmd("t5b", 16'h0004, 16'h0004);
        accept("t5b");

        send("AB*");
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("t6_op_a", op_a, 0);
        chk("t6_op_b", op_b, 0);
        chk("t6_valid", cmd_valid, 0);
        chk("t6_err", err, 0);
        send("1*1"); put(CR);
        expect_cmd("t6", 16'h0001, 16'h0001);
        accept("t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/hex_cmd_parser.md
Name: hex_cmd_parser

Overview:
- Consumes the received-byte stream from the UART receiver and parses ASCII command lines of the form `<hexA>*<hexB><CR|LF>` into two binary operands for the multiplier datapath.
- Presents each parsed operand pair with a valid/ready handshake.
- Reports malformed input with a one-cycle error pulse and error code, then resynchronises.

Parameters:
- DIGITS, 4, maximum hex digits per operand. Operand width OP_W = 4*DIGITS, a derived localparam.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received ASCII byte; valid only in cycles where rx_done=1
- rx_done  in  1  one-cycle strobe, byte available
- op_a  out  OP_W  operand A, right-aligned, zero-extended
- op_b  out  OP_W  operand B, right-aligned, zero-extended
- cmd_valid  out  1  operand pair valid; held until accepted
- cmd_ready  in  1  downstream accepts the pair when cmd_valid & cmd_ready
- err  out  1  one-cycle error pulse
- err_code  out  2  cause, valid while err=1: 0 overrun, 1 bad character, 2 digit overflow, 3 syntax

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (port name reset).
- Reset values: op_a=0, op_b=0, cmd_valid=0, err=0, err_code=0, state=GET_A, digit counters=0, accumulators=0.
  - Reset mid-line discards the partial line.
- Byte classes:
  - hex: '0'-'9', 'A'-'F', 'a'-'f' (0x30-39, 0x41-46, 0x61-66)
  - STAR: 0x2A
  - TERM: CR 0x0D or LF 0x0A
  - SPACE: 0x20, always ignored with no effect in GET_A and GET_B
  - anything else is bad
- Bytes are processed only in cycles with rx_done=1. A byte accepted in cycle N updates state, accumulator, cmd_valid and err at N+1. Each byte is processed exactly once.
- Accumulate: acc <= {acc[OP_W-5:0], nibble}; digit count increments by 1.
- State GET_A:
  - hex with cnt_a<DIGITS: accumulate into A.
  - hex with cnt_a==DIGITS: error 2.
  - STAR with cnt_a>0: go to GET_B.
  - STAR with cnt_a==0: error 3.
  - TERM with cnt_a==0: ignored. This allows CRLF pairs and blank lines.
  - TERM with cnt_a>0: error 3.
  - bad: error 1.
- State GET_B:
  - hex: same digit rule as A, accumulating into B.
  - STAR: error 3.
  - TERM with cnt_b==0: error 3.
  - TERM with cnt_b>0: load op_a<=acc_a and op_b<=acc_b, set cmd_valid=1, go to HOLD.
  - bad: error 1.
- State HOLD:
  - op_a, op_b and cmd_valid are stable.
  - When cmd_valid & cmd_ready: cmd_valid=0 next cycle, clear accumulators and counters, go to GET_A. op_a/op_b keep their last values.
  - Any rx_done in HOLD, including the handshake cycle itself, drops the byte and signals error 0.
- Any error (codes 1-3):
  - err=1 for exactly one cycle with err_code.
  - The offending byte is consumed.
  - Accumulators and counters clear; state goes to GET_A.
  - op_a, op_b and cmd_valid are unaffected.
- Overrun error (code 0): state remains HOLD.
- err deasserts the cycle after its pulse unless a new error byte arrives.
- Back-to-back rx_done in consecutive cycles must be handled: no byte lost outside HOLD.
- cmd_ready is ignored while cmd_valid=0.

Test Plan:
- Send "12*AB\r"; hold cmd_ready=0 for 5 cycles, then 1 -> cmd_valid rises 1 cycle after the CR strobe with op_a=0x0012, op_b=0x00AB. cmd_valid stays high and the operands stay stable until the handshake, then cmd_valid drops next cycle.
- Send "fFfF * 1\r\n" with cmd_ready=1 -> op_a=0xFFFF, op_b=0x0001, exactly one cmd_valid. The LF that follows the accept is ignored (no err).
- Send "12345*1\r" -> err pulse with code 2 on the '5'. Then send "7*3\r" -> op_a=0x0007, op_b=0x0003.
- Send "*5\r", "5*\r", "G\r" -> errors coded 3, 3, 1 respectively. No cmd_valid in any case.
- After "2*3\r" with cmd_ready=0, send 'X' while in HOLD -> err code 0. op_a=2 and op_b=3 stay intact; after the handshake, "4*4\r" yields op_a=4, op_b=4.
- Assert reset after "AB*" -> all outputs 0. A following "1*1\r" yields op_a=1, op_b=1.
